// File: rtl/spwtcr_tx_ds_encoder_if.sv
// ---------------------------------------------------------------------------
// spwtcr_tx_ds_encoder_if
//
// Character request channel between the transmit controller and the
// SpaceWire Data-Strobe encoder. The transfer is a plain ready/valid
// handshake: a character moves into the encoder when tx_valid and tx_ready
// are both high on a rising clock edge.
//
// Signals:
//   tx_type  [2:0] character type (0 FCT, 1 EOP, 2 EEP, 3 DATA, 4 TIMECODE,
//                  5-7 NULL)
//   tx_data  [7:0] payload for DATA / TIMECODE characters
//   tx_valid       request from the controller
//   tx_ready       encoder buffer is empty and the link is enabled
//
// Modports:
//   master  transmit controller side (drives type/data/valid)
//   slave   encoder side (drives ready)
// ---------------------------------------------------------------------------
interface spwtcr_tx_ds_encoder_if;
  logic [2:0] tx_type;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_type,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_type,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/spwtcr_tx_ds_encoder.sv
// ---------------------------------------------------------------------------
// spwtcr_tx_ds_encoder
//
// Transmit-side Data-Strobe encoder of the SpaceWire codec. Characters are
// taken from a one-entry ready/valid buffer, expanded into SpaceWire bit
// sequences with odd parity, and shifted out on Dout/Sout at a bit period of
// tx_div+1 clock cycles. When no character is pending a NULL (ESC+FCT) is
// sent. Dropping enable_tx aborts immediately and drives both pins low.
//
// Ports:
//   CLOCK      system clock, rising edge
//   RESET      asynchronous reset, active high
//   enable_tx  link transmit enable; low forces the encoder to OFF
//   tx_div     bit period minus one, sampled at every bit boundary
//   tx_if      character request channel (slave modport)
//   Dout       SpaceWire data line (registered)
//   Sout       SpaceWire strobe line (registered)
//   tx_busy    high while a character is being shifted out
// ---------------------------------------------------------------------------
module spwtcr_tx_ds_encoder #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 enable_tx,
  input  logic [DIV_WIDTH-1:0] tx_div,
  spwtcr_tx_ds_encoder_if.slave tx_if,
  output logic                 Dout,
  output logic                 Sout,
  output logic                 tx_busy
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [2:0] TYPE_FCT  = 3'd0;
  localparam logic [2:0] TYPE_EOP  = 3'd1;
  localparam logic [2:0] TYPE_EEP  = 3'd2;
  localparam logic [2:0] TYPE_DATA = 3'd3;
  localparam logic [2:0] TYPE_TIME = 3'd4;
  localparam logic [2:0] TYPE_NULL = 3'd5;

  state_t                 state, state_nxt;

  logic                   buf_full, buf_full_nxt;
  logic [2:0]             buf_type, buf_type_nxt;
  logic [7:0]             buf_data, buf_data_nxt;

  // Bits still to be emitted, next bit in position 0.
  logic [13:0]            shreg, shreg_nxt;
  // Number of bits still waiting in shreg (the bit on the line excluded).
  logic [3:0]             bits_left, bits_left_nxt;
  logic [DIV_WIDTH-1:0]   div_cnt, div_cnt_nxt;

  // Payload XOR of the last sub-character of the character most recently
  // loaded. It is written at LOAD, so by the time the next LOAD happens it
  // describes a sub-character that has been fully sent; an abort clears it.
  logic                   hist, hist_nxt;

  logic                   dout_nxt, sout_nxt;
  logic                   ready_q, ready_nxt;
  logic                   accept;
  logic                   emit;
  logic                   emit_bit;

  logic [2:0]             char_type;
  logic [13:0]            lc_bits;
  logic [3:0]             lc_len;
  logic                   lc_hist;

  // Control character P,1,c0,c1 packed with the first bit sent in bit 0.
  // P = NOT(h XOR 1) = h.
  function automatic logic [3:0] ctrl_char(input logic h, input logic c0,
                                           input logic c1);
    return {c1, c0, 1'b1, h};
  endfunction

  // Data character P,0,d0..d7 packed with the first bit sent in bit 0.
  // P = NOT(h XOR 0) = NOT h.
  function automatic logic [9:0] data_char(input logic h, input logic [7:0] d);
    return {d, 1'b0, ~h};
  endfunction

  assign tx_if.tx_ready = ready_q;

  // Builds the bit sequence of the character LOAD would take right now.
  // An empty buffer yields a NULL. For the two-part characters the second
  // sub-character always sees a history of 0, because the payload of ESC
  // (c0=c1=1) XORs to 0.
  always_comb begin : build_char
    char_type = buf_full ? buf_type : TYPE_NULL;
    lc_bits   = '0;
    lc_len    = 4'd8;
    lc_hist   = 1'b0;
    case (char_type)
      TYPE_FCT: begin
        lc_bits = {10'd0, ctrl_char(hist, 1'b0, 1'b0)};
        lc_len  = 4'd4;
        lc_hist = 1'b0;
      end
      TYPE_EOP: begin
        lc_bits = {10'd0, ctrl_char(hist, 1'b1, 1'b0)};
        lc_len  = 4'd4;
        lc_hist = 1'b1;
      end
      TYPE_EEP: begin
        lc_bits = {10'd0, ctrl_char(hist, 1'b0, 1'b1)};
        lc_len  = 4'd4;
        lc_hist = 1'b1;
      end
      TYPE_DATA: begin
        lc_bits = {4'd0, data_char(hist, buf_data)};
        lc_len  = 4'd10;
        lc_hist = ^buf_data;
      end
      TYPE_TIME: begin
        lc_bits = {data_char(1'b0, buf_data), ctrl_char(hist, 1'b1, 1'b1)};
        lc_len  = 4'd14;
        lc_hist = ^buf_data;
      end
      default: begin
        lc_bits = {6'd0, ctrl_char(1'b0, 1'b0, 1'b0),
                   ctrl_char(hist, 1'b1, 1'b1)};
        lc_len  = 4'd8;
        lc_hist = 1'b0;
      end
    endcase
  end

  // Next-state and datapath logic. LOAD is the final cycle of the previous
  // character's last bit period, so it also acts as the bit boundary that
  // emits the first bit of the new character. The FSM enters LOAD on the
  // edge after which no bits remain and the divisor reaches zero, which
  // keeps the line gap-free for every tx_div value including zero.
  always_comb begin : next_state_logic
    state_nxt     = state;
    buf_full_nxt  = buf_full;
    buf_type_nxt  = buf_type;
    buf_data_nxt  = buf_data;
    shreg_nxt     = shreg;
    bits_left_nxt = bits_left;
    div_cnt_nxt   = div_cnt;
    hist_nxt      = hist;
    dout_nxt      = Dout;
    sout_nxt      = Sout;
    emit          = 1'b0;
    emit_bit      = 1'b0;
    tx_busy       = (state == ST_SHIFT);
    accept        = tx_if.tx_valid & ready_q;

    case (state)
      ST_OFF: begin
        dout_nxt     = 1'b0;
        sout_nxt     = 1'b0;
        hist_nxt     = 1'b0;
        buf_full_nxt = 1'b0;
        if (enable_tx) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        emit          = 1'b1;
        emit_bit      = lc_bits[0];
        shreg_nxt     = lc_bits >> 1;
        bits_left_nxt = lc_len - 4'd1;
        div_cnt_nxt   = tx_div;
        hist_nxt      = lc_hist;
        buf_full_nxt  = 1'b0;
      end
      ST_SHIFT: begin
        if (div_cnt == '0) begin
          emit          = 1'b1;
          emit_bit      = shreg[0];
          shreg_nxt     = shreg >> 1;
          bits_left_nxt = bits_left - 4'd1;
          div_cnt_nxt   = tx_div;
        end else begin
          div_cnt_nxt = div_cnt - DIV_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase

    // Strobe toggles only when the data line does not, so Dout^Sout
    // changes exactly once per bit.
    if (emit) begin
      dout_nxt = emit_bit;
      sout_nxt = (emit_bit == Dout) ? ~Sout : Sout;
    end

    if (state == ST_LOAD || state == ST_SHIFT) begin
      state_nxt = (bits_left_nxt == 4'd0 && div_cnt_nxt == '0) ? ST_LOAD
                                                                 : ST_SHIFT;
    end

    if (accept) begin
      buf_full_nxt = 1'b1;
      buf_type_nxt = tx_if.tx_type;
      buf_data_nxt = tx_if.tx_data;
    end

    // Disable wins over everything, including a character mid-flight and
    // one accepted on this very edge.
    if (!enable_tx) begin
      state_nxt     = ST_OFF;
      dout_nxt      = 1'b0;
      sout_nxt      = 1'b0;
      buf_full_nxt  = 1'b0;
      hist_nxt      = 1'b0;
      shreg_nxt     = '0;
      bits_left_nxt = '0;
      div_cnt_nxt   = '0;
    end

    // tx_ready is registered so that it can read 1 while in reset; out of
    // reset it always equals (buffer empty AND state != OFF).
    ready_nxt = (state_nxt != ST_OFF) && !buf_full_nxt;
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK or posedge RESET) begin : state_regs
    if (RESET) begin
      state     <= ST_OFF;
      buf_full  <= 1'b0;
      buf_type  <= '0;
      buf_data  <= '0;
      shreg     <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      hist      <= 1'b0;
      Dout      <= 1'b0;
      Sout      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      buf_full  <= buf_full_nxt;
      buf_type  <= buf_type_nxt;
      buf_data  <= buf_data_nxt;
      shreg     <= shreg_nxt;
      bits_left <= bits_left_nxt;
      div_cnt   <= div_cnt_nxt;
      hist      <= hist_nxt;
      Dout      <= dout_nxt;
      Sout      <= sout_nxt;
      ready_q   <= ready_nxt;
    end
  end

endmodule

// File: doc/spwtcr_tx_ds_encoder.md
# spwtcr_tx_ds_encoder

Transmit-side Data-Strobe encoder of the SpaceWire codec: the counterpart of the receiver clock-recovery path. It accepts characters from the transmit controller through a one-entry ready/valid buffer and serializes them onto the Dout/Sout link pins at a programmable bit rate. It generates SpaceWire odd parity, inserts NULLs whenever no character is pending, and forces the link pins low when transmission is disabled. Downstream, `Din ^ Sin` recovers one clock edge per bit.

## Interface
- `DIV_WIDTH`, default 8: width of the bit-period divisor.
- `CLOCK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  asynchronous reset, active-high.
- `enable_tx`  in  1  link transmit enable. Low forces the encoder idle.
- `tx_div`  in  DIV_WIDTH  bit period = tx_div+1 CLOCK cycles. Sampled at each bit boundary.
- `tx_type`  in  3  character type: 0 FCT, 1 EOP, 2 EEP, 3 DATA, 4 TIMECODE, 5–7 NULL.
- `tx_data`  in  8  payload for DATA/TIMECODE; ignored otherwise.
- `tx_valid`  in  1  character request.
- `tx_ready`  out  1  buffer empty; transfer occurs when tx_valid & tx_ready.
- `Dout`  out  1  SpaceWire data line (registered).
- `Sout`  out  1  SpaceWire strobe line (registered).
- `tx_busy`  out  1  high while a character is being shifted out.

## Operation
- **Reset values:**
  - Dout=0, Sout=0, tx_busy=0, tx_ready=1.
  - Buffer empty, parity history=0, state OFF.
- **Character formats** (bits sent left to right, payload LSB first):
  - Data character: P, 0, d0..d7 (10 bits).
  - Control character: P, 1, c0, c1 (4 bits). FCT c=00, EOP c=10, EEP c=01, ESC c=11 (c0 first).
  - NULL: ESC followed by FCT.
  - TIMECODE: ESC followed by a data character carrying tx_data.
  - Each half of NULL and TIMECODE is a separate sub-character with its own parity.
- **Parity:** P = NOT(XOR of previous sub-character's payload bits XOR current flag), which gives odd parity over {previous payload, P, flag}.
  - The history is the payload XOR of the last sub-character fully sent.
  - History clears to 0 on RESET and while enable_tx=0.
- **DS encoding:** at each bit boundary Dout takes the new bit. Sout toggles if and only if the new bit equals the current Dout, so Dout^Sout toggles exactly once per bit.
- **States:**
  - OFF: Dout=Sout=0, buffer flushed, tx_ready=0. Leaves to LOAD when enable_tx=1.
  - LOAD (1 cycle):
    - Buffer full: take the character from the buffer and free it.
    - Buffer empty: take a NULL.
    - Build a shift register of up to 14 bits plus a bit count, then go to SHIFT.
  - SHIFT: emit one bit per period. After the last bit's period go to LOAD. LOAD occupies the final cycle of that period, so there is no gap between characters.
- **Abort:** enable_tx=0 in any state goes to OFF on the next edge, mid-character included. Dout and Sout go to 0 on that edge, and any buffered character is discarded.
- **Handshake:**
  - tx_ready = buffer empty AND state≠OFF.
  - A buffer freed in LOAD shows tx_ready=1 on the next cycle.
  - Simultaneous accept and load cannot occur, because accept requires an empty buffer.
- **Reserved types 5–7** are accepted and transmitted as NULL.

## Timing
- **Bit period:** tx_div+1 cycles; tx_div=0 gives one bit per CLOCK.
- **Divisor counter:** counts down from tx_div and reloads at each bit boundary. A tx_div change takes effect at the next boundary and never truncates the current bit.
- **Start-up:** after enable_tx rises, the first bit of the first NULL appears on Dout 2 cycles later (OFF→LOAD→SHIFT).
- **Latency:** a character accepted mid-transmission starts immediately after the current character ends. Worst case is 14 bit periods (a TIMECODE in progress).
- **tx_busy:** 1 during SHIFT, 0 in OFF and LOAD.

## Test plan
- **Idle NULL stream:** RESET, then enable_tx=1, tx_div=0, tx_valid=0.
  - Required Dout bits: 0,1,1,1,0,1,0,0, repeating.
  - Required Sout: 1,1,0,1,1,1,1,0.
  - Dout^Sout must toggle every cycle.
- **Data character:** send DATA 0x55 during the first NULL.
  - Immediately after that NULL, Dout must be 1,0,1,0,1,0,1,0,1,0.
  - tx_ready must return to 1 one cycle after the LOAD.
- **Time-code parity:** send TIMECODE 0x00 after FCT (history 0).
  - Required ESC: 0,1,1,1. Required data character: 1,0, then eight 0s.
  - The following NULL's ESC starts with P=0.
- **Divisor:** tx_div=3. Each Dout bit must hold exactly 4 cycles.
  - Change tx_div to 1 mid-bit: the current bit still lasts 4 cycles and the next bit lasts 2.
- **Abort:** drop enable_tx during bit 5 of a DATA character.
  - Next edge: Dout=Sout=0, tx_busy=0, tx_ready=0, buffered character lost.
  - Re-enable: the first sub-character is ESC with P=0.
- **Async reset mid-SHIFT:** Dout/Sout clear to 0 immediately without waiting for a CLOCK edge, and all state returns to reset values.
